// File: rtl/inject_port_fifo.sv
// Injection FIFO: turns a level-held select-stage packet into one push per new packet.
// Define INJECT_DROP_CNT_EN to build the saturating drop counter.
module inject_port_fifo #(
    parameter int N2    = 13,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N2-1:0]          in_packet,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [N2-2:0]          out_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             inj_count,
    output logic [7:0]             drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int DW = N2 - 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [N2-1:0] last_pkt_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [7:0]    inj_cnt_q, inj_cnt_d;
    logic          evt, full, pop, push;

    always_comb begin
        evt = in_packet[N2-1] &&
              (!last_pkt_q[N2-1] || in_packet[DW-1:0] != last_pkt_q[DW-1:0]);
        full = (level_q == FULL_LVL);
        pop = out_valid_q && out_ready;
        push = evt && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d = level_q + LW'(push) - LW'(pop);
        inj_cnt_d = inj_cnt_q + 8'(pop);
        out_valid_d = (level_d != '0);
        out_data_d = '0;
        // The next head is the entry being written this edge when it lands at the new read pointer
        if (level_d != '0) begin
            if (push && wr_ptr_q == rd_ptr_d) out_data_d = in_packet[DW-1:0];
            else                              out_data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_packet[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pkt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            inj_cnt_q   <= '0;
        end else begin
            last_pkt_q  <= in_packet;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            inj_cnt_q   <= inj_cnt_d;
        end
    end

`ifdef INJECT_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop = evt && full && !pop;
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 8'h00;
`endif

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign fifo_level = level_q;
    assign inj_count  = inj_cnt_q;
endmodule

// File: tb/tb_inject_port_fifo.sv
// Directed bench for inject_port_fifo with a reference model and payload scoreboard.
// Expected drop count follows INJECT_DROP_CNT_EN.
module tb_inject_port_fifo;
    localparam int N2 = 13;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N2-1:0] in_packet = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [N2-2:0] out_data;
    logic [2:0]    fifo_level;
    logic [7:0]    inj_count;
    logic [7:0]    drop_count;

    int checks = 0;
    int errors = 0;

    logic [N2-2:0] sb[$];
    logic [N2-1:0] m_last = '0;
    int            m_level = 0;
    int            m_inj = 0;
    int            m_drop = 0;

    inject_port_fifo #(.N2(N2), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_packet(in_packet),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .fifo_level(fifo_level),
        .inj_count(inj_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_last = '0;
        m_level = 0;
        m_inj = 0;
        m_drop = 0;
    endtask

    // One clock: predict this edge, score any pop, then advance to edge+1.
    task automatic tick();
        logic ev, pop, push;
        logic [N2-2:0] exp;
        ev = in_packet[N2-1] &&
             (!m_last[N2-1] || in_packet[N2-2:0] != m_last[N2-2:0]);
        pop = (m_level != 0) && out_ready;
        chk("out_valid", 32'(out_valid), 32'(m_level != 0));
        if (pop) begin
            exp = (sb.size() != 0) ? sb.pop_front() : 'x;
            chk("pop_data", 32'(out_data), 32'(exp));
        end
        push = ev && (m_level < DEPTH || pop);
        if (push) sb.push_back(in_packet[N2-2:0]);
`ifdef INJECT_DROP_CNT_EN
        if (ev && !push && m_drop < 255) m_drop++;
`endif
        m_level = m_level + int'(push) - int'(pop);
        m_inj = (m_inj + int'(pop)) % 256;
        m_last = in_packet;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_level"}, 32'(fifo_level), 32'(m_level));
        chk({tag, "_inj"}, 32'(inj_count), 32'(m_inj));
        chk({tag, "_drop"}, 32'(drop_count), 32'(m_drop));
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_inj", 32'(inj_count), 0);
        chk("rst_drop", 32'(drop_count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Held packet -> single transfer, one-cycle latency
        in_packet = 13'h10A5;
        out_ready = 1'b1;
        tick();
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 32'h0A5);
        for (int i = 0; i < 9; i++) tick();
        chk("held_inj", 32'(inj_count), 1);
        chk("held_level", 32'(fifo_level), 0);
        chk("held_data0", 32'(out_data), 0);

        // Five distinct packets into a stalled FIFO
        in_packet = '0;
        out_ready = 1'b0;
        do_reset();
        for (int p = 1; p <= 5; p++) begin
            in_packet = {1'b1, 12'(p)};
            tick();
        end
        tick();
        chk("fill_level", 32'(fifo_level), 4);
`ifdef INJECT_DROP_CNT_EN
        chk("fill_drop", 32'(drop_count), 1);
`else
        chk("fill_drop", 32'(drop_count), 0);
`endif
        chk("stall_head", 32'(out_data), 32'h001);
        tick();
        chk("stall_stable", 32'(out_data), 32'h001);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("drain_inj", 32'(inj_count), 4);
        chk_state("drain");

        // Full FIFO with simultaneous pop and push
        out_ready = 1'b0;
        for (int p = 16; p < 20; p++) begin
            in_packet = {1'b1, 12'(p)};
            tick();
        end
        chk("full_level", 32'(fifo_level), 4);
        out_ready = 1'b1;
        in_packet = 13'h1014;
        tick();
        chk("pp_level", 32'(fifo_level), 4);
        chk_state("pp");
        for (int i = 0; i < 5; i++) tick();
        chk("pp_empty", 32'(fifo_level), 0);

        // Present flag toggle with the same payload
        out_ready = 1'b0;
        in_packet = 13'h13C3;
        tick();
        in_packet = 13'h03C3;
        tick();
        in_packet = 13'h13C3;
        tick();
        tick();
        chk("toggle_level", 32'(fifo_level), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk_state("toggle");

        // Asynchronous reset with three entries stored
        out_ready = 1'b0;
        for (int p = 33; p < 36; p++) begin
            in_packet = {1'b1, 12'(p)};
            tick();
        end
        chk("pre_rst_level", 32'(fifo_level), 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_level", 32'(fifo_level), 0);
        chk("arst_data", 32'(out_data), 0);
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("reinj_level", 32'(fifo_level), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("reinj_inj", 32'(inj_count), 1);
        chk_state("reinj");

        // 257 transfers wrap the injection counter
        in_packet = '0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            in_packet = {1'b1, 12'(i)};
            tick();
        end
        for (int i = 0; i < 3; i++) tick();
        chk("wrap_inj", 32'(inj_count), 1);

        // 300 drops saturate the drop counter
        in_packet = '0;
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 304; i++) begin
            in_packet = {1'b1, 12'(i)};
            tick();
        end
`ifdef INJECT_DROP_CNT_EN
        chk("sat_drop", 32'(drop_count), 255);
`else
        chk("sat_drop", 32'(drop_count), 0);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk_state("final");
        chk("sb_left", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inject_port_fifo.md
INJECT_PORT_FIFO -- requirements
Module: inject_port_fifo

Interface
REQ-001 The block SHALL have parameter N2, default 13, meaning the packet width from the select stage (1 present flag plus 2x6-bit step counts).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_packet, input, N2 bits: level-held packet from one select-stage router output; bit N2-1 is the present flag, bits N2-2:0 are the payload.
REQ-006 The block SHALL have port out_ready, input, 1 bit: the router local port accepts the head packet this cycle.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the head packet is available.
REQ-008 The block SHALL have port out_data, output, N2-1 bits: the head payload.
REQ-009 The block SHALL have port fifo_level, output, log2(DEPTH)+1 bits: current occupancy.
REQ-010 The block SHALL have port inj_count, output, 8 bits: packets accepted by the router, wrapping modulo 256.
REQ-011 The block SHALL have port drop_count, output, 8 bits: packets discarded because the FIFO was full, saturating at 255.

Function
REQ-012 The block SHALL register in_packet every cycle into last_pkt.
REQ-013 The block SHALL detect an event when in_packet[N2-1]=1 and either last_pkt[N2-1]=0 or in_packet[N2-2:0]≠last_pkt[N2-2:0].
- A held, unchanged packet SHALL produce exactly one event.
REQ-014 On an event with the FIFO not full, the block SHALL write in_packet[N2-2:0] at the tail on that clock edge.
REQ-015 On an event with the FIFO full and no pop in the same cycle, the block SHALL discard the packet and increment drop_count, saturating at 255.
REQ-016 out_valid SHALL equal (fifo_level≠0), and out_data SHALL equal the head entry; both SHALL be driven from registers.
REQ-017 When out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-018 A pop SHALL occur on a clock edge where out_valid=1 and out_ready=1; each pop SHALL advance the head and increment inj_count modulo 256.
REQ-019 When a push and a pop coincide, fifo_level SHALL be unchanged; on a full FIFO the push SHALL be accepted with no drop.
REQ-020 The first out_valid=1 SHALL appear one cycle after the event edge; a packet SHALL never be pushed and popped in the same cycle.
REQ-021 Ordering SHALL be strict first-in, first-out; read and write pointers SHALL wrap modulo DEPTH.
REQ-022 The block SHALL ignore out_ready while out_valid=0.

Reset
REQ-023 While rst_n=0, the following SHALL be 0 regardless of clk: last_pkt, both pointers, fifo_level, out_valid, out_data, inj_count and drop_count.
REQ-024 Reset asserted mid-operation SHALL discard all stored packets; after release, a still-present in_packet SHALL count as a new event.
REQ-025 FIFO storage contents need not be cleared, but out_data SHALL read 0 while empty.

Configuration
REQ-026 Feature macro INJECT_DROP_CNT_EN SHALL control the drop counter.
- When defined: drop_count SHALL behave per REQ-015.
- When undefined: drop_count SHALL be constant 0, no counter logic SHALL be synthesized, and full-FIFO drops SHALL still occur silently.

Verification
REQ-027 The bench SHALL cover: reset, in_packet=13'h1_0A5 held 10 cycles, out_ready=1 -> exactly one transfer with out_data=12'h0A5, inj_count=1.
REQ-028 The bench SHALL cover: out_ready=0, five distinct present packets 12'h001..12'h005 -> fifo_level=4, drop_count=1 (0 without macro); then out_ready=1 -> out_data 001,002,003,004 in order, inj_count=4.
REQ-029 The bench SHALL cover: FIFO full, out_ready=1, new event in the same cycle -> no drop, fifo_level stays 4.
REQ-030 The bench SHALL cover: present flag toggling 1,0,1 with the same payload 12'h3C3 -> two pushes.
REQ-031 The bench SHALL cover: rst_n pulsed low asynchronously with 3 entries stored -> out_valid=0 and fifo_level=0 immediately; after release, the held packet is re-injected once.
REQ-032 The bench SHALL cover: 257 single transfers -> inj_count=1; 300 drops with the macro defined -> drop_count=255.
